// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU_Control codes for the M-type operations,
// the mul/div FSM state type and the default data width.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_MPY  = 4'b1010;
    localparam logic [3:0] ALU_MPYH = 4'b1011;
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_MOD  = 4'b1101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } md_state_e;

    function automatic logic is_muldiv_op(input logic [3:0] code);
        return code inside {ALU_MPY, ALU_MPYH, ALU_DIV, ALU_MOD};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared 2*XLEN accumulator: shift-add for
// multiply (multiplier in the low half), restoring shift-subtract for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic            w_fits;
    logic [XLEN-1:0] w_diff;

    assign w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);

    // The partial remainder is always below the divisor, so the difference
    // fits in XLEN bits whenever the trial subtraction succeeds.
    assign w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    assign w_fits   = (w_rem_sh >= {1'b0, i_opnd});
    assign w_diff   = w_rem_sh[XLEN-1:0] - i_opnd;

    assign o_acc = !i_is_div ? {w_sum, i_acc[XLEN-1:1]} :
                   w_fits    ? {w_diff, i_acc[XLEN-2:0], 1'b1} :
                               {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed MPY/MPYH/DIV/MODULO unit for the EX stage. Fixed
// latency of XLEN+2 cycles from accepted start to the done pulse.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      ALU_Control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    md_state_e         r_state;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg;
    logic              r_div0;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_is_div;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    assign w_is_div = (r_op == ALU_DIV) || (r_op == ALU_MOD);
    assign w_abs_a  = r_a[XLEN-1] ? -r_a : r_a;
    assign w_abs_b  = r_b[XLEN-1] ? -r_b : r_b;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_next)
    );

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = w_rem;
        case (r_op)
            ALU_MPY:  w_fix_result = w_prod[XLEN-1:0];
            ALU_MPYH: w_fix_result = w_prod[2*XLEN-1:XLEN];
            ALU_DIV:  w_fix_result = r_div0 ? '1 : w_quot;
            default:  w_fix_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears the datapath registers too, so
        // the unit leaves reset in a fully known state with result = 0.
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !flush && is_muldiv_op(ALU_Control)) begin
                        r_op    <= ALU_Control;
                        r_a     <= operand_a;
                        r_b     <= operand_b;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Multiply keeps the multiplier in the low half; divide
                        // keeps the dividend there and shifts quotient bits in.
                        r_acc   <= w_is_div ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
                        r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
                        r_neg   <= (r_op == ALU_MOD) ? r_a[XLEN-1] : (r_a[XLEN-1] ^ r_b[XLEN-1]);
                        r_div0  <= (r_b == '0);
                        r_cnt   <= CNT_W'(XLEN - 1);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_result <= w_fix_result;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic signed reference model.
module tb_muldiv_unit;
    import cpu_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            flush;
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int              n_checks = 0;
    int              n_pass   = 0;
    logic [XLEN-1:0] last_exp = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_Control (alu_ctl),
        .operand_a   (op_a),
        .operand_b   (op_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p  = sa * sb;
        case (op)
            ALU_MPY:  return p[31:0];
            ALU_MPYH: return p[63:32];
            ALU_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise);
        logic [31:0] exp = ref_model(op, a, b);
        bit          ok  = 1'b1;
        start   = 1'b1;
        alu_ctl = op;
        op_a    = a;
        op_b    = b;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < LAT; n++) begin
            if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            if (noise) begin
                start   = 1'($urandom_range(0, 1));
                alu_ctl = 4'(ALU_MPY + 4'($urandom_range(0, 3)));
                op_a    = $urandom;
                op_b    = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy window"}, 32'(ok), 32'd1);
        check({tag, " done"}, 32'({done, busy}), 32'b10);
        check({tag, " result"}, result, exp);
        last_exp = exp;
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit ok = 1'b1;
        repeat (cycles) begin
            if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [3:0]  r_op_sel;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        alu_ctl = 4'b0000;
        op_a    = '0;
        op_b    = '0;
        repeat (2) @(negedge clk);
        check("reset busy/done", 32'({busy, done}), 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mpy 7*-3", ALU_MPY, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mpy 7*-3 const", result, 32'hFFFF_FFEB);
        @(negedge clk);
        check("done one cycle", 32'(done), 32'd0);

        run_op("mpyh min*min", ALU_MPYH, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mpyh const", result, 32'h4000_0000);
        run_op("mpy b2b", ALU_MPY, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mpy b2b const", result, 32'h0000_0000);
        @(negedge clk);

        run_op("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div -7/2 const", result, 32'hFFFF_FFFD);
        run_op("mod -7%2", ALU_MOD, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("mod -7%2 const", result, 32'hFFFF_FFFF);
        run_op("div 5/0", ALU_DIV, 32'd5, 32'd0, 1'b0);
        check("div 5/0 const", result, 32'hFFFF_FFFF);
        run_op("div -5/0", ALU_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("mod 5%0", ALU_MOD, 32'd5, 32'd0, 1'b0);
        check("mod 5%0 const", result, 32'd5);
        run_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div ovf const", result, 32'h8000_0000);
        run_op("mod ovf", ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("mod ovf const", result, 32'd0);
        @(negedge clk);

        // Randomized operations with stray starts/operand churn while busy.
        for (int i = 0; i < 24; i++) begin
            r_op_sel = 4'(ALU_MPY + 4'($urandom_range(0, 3)));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($signed(-$urandom_range(0, 100))); rb = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            run_op("random", r_op_sel, ra, rb, 1'b1);
            if (i % 3 == 0) @(negedge clk);
        end
        @(negedge clk);

        // Flush mid-CALC: no done, result keeps the last value.
        start   = 1'b1;
        alu_ctl = ALU_DIV;
        op_a    = 32'd1000;
        op_b    = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy low", 32'(busy), 32'd0);
        watch_quiet("flush no done", 40);
        check("flush result held", result, last_exp);

        // Reset mid-operation.
        start   = 1'b1;
        alu_ctl = ALU_MPY;
        op_a    = 32'd12345;
        op_b    = 32'd678;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midop reset busy/done", 32'({busy, done}), 32'd0);
        check("midop reset result", result, 32'd0);
        last_exp = '0;
        watch_quiet("midop reset quiet", 40);

        // Invalid codes, including those adjacent to the valid range.
        start   = 1'b1;
        alu_ctl = 4'b0000;
        @(negedge clk);
        alu_ctl = 4'b1001;
        @(negedge clk);
        alu_ctl = 4'b1110;
        @(negedge clk);
        start = 1'b0;
        watch_quiet("invalid code ignored", 40);

        // Flush and start together in IDLE.
        start   = 1'b1;
        flush   = 1'b1;
        alu_ctl = ALU_MPY;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        watch_quiet("flush beats start", 40);
        check("idle result held", result, last_exp);

        // Flush with start during DONE: pulse completes, new start dropped.
        run_op("pre-flush mpyh", ALU_MPYH, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
        start   = 1'b1;
        flush   = 1'b1;
        alu_ctl = ALU_DIV;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        watch_quiet("flush in done", 40);
        check("flush in done result", result, last_exp);

        run_op("final mod", ALU_MOD, 32'd100, 32'hFFFF_FFF9, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
